// File: rtl/jk_cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cnt_pkg
//  Description : Shared types and helpers for the JK-cell up/down counter:
//                direction encodings, per-edge operating mode, and the
//                all-ones terminal value for a given counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_cnt_pkg;

    // Direction encodings as seen on x_in.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // What the counter does on the coming edge. Load wins over count,
    // count wins over hold.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        LOAD  = 2'd2
    } mode_t;

    // All-ones value of a counter of the given width. Widths of 32 and
    // above saturate to a full 32-bit mask.
    function automatic logic [31:0] max_val(input int unsigned width);
        logic [31:0] r;
        if (width >= 32) begin
            r = '1;
        end else begin
            r = (32'd1 << width) - 32'd1;
        end
        return r;
    endfunction

endpackage : jk_cnt_pkg
`default_nettype wire

// File: rtl/jk_updown_counter_jk_cell.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cell
//  Description : Single JK flip-flop. Q_next = J&~Q | ~K&Q, so J=K=1 toggles,
//                J=K=0 holds, J=1/K=0 sets and J=0/K=1 clears. Asynchronous
//                active-low reset clears Q.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cell (
    input  logic Clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    // JK storage element with asynchronous clear.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= (j & ~r_q) | (~k & r_q);
        end
    end

    assign q = r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jk_updown_counter
//  Description : Parametrised synchronous up/down counter built from WIDTH
//                JK cells. x_in picks the direction, load gives a synchronous
//                parallel load, SAT selects wrap (0) or saturate (1) at the
//                terminal value. tc is a combinational terminal-count flag,
//                ovf a registered one-cycle pulse after each counted terminal
//                event.
//                Optional build macro JK_CNT_MOD_EN adds a mod_max input that
//                replaces the all-ones terminal value; J/K are then derived
//                from a computed next-state value instead of ripple toggles.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_updown_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = 4,    // counter width, must be >= 2 (and <= 32)
    parameter bit SAT   = 1'b0  // 0 = wrap at terminal, 1 = saturate
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef JK_CNT_MOD_EN
    input  logic [WIDTH-1:0] mod_max,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    mode_t            w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_max;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_tc;
    logic             r_ovf;

    // Resolve what happens on the next edge: load beats count beats hold.
    always_comb begin
        w_mode = HOLD;
        if (load) begin
            w_mode = LOAD;
        end else if (en) begin
            w_mode = COUNT;
        end
    end

`ifdef JK_CNT_MOD_EN
    // Programmable terminal value; anything at or above it counts as the top
    // when going up, so a load beyond mod_max still wraps/clamps cleanly.
    assign w_max    = mod_max;
    assign w_at_top = (w_q >= w_max);
`else
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(max_val(WIDTH));

    assign w_max    = c_MAX;
    assign w_at_top = (w_q == w_max);
`endif

    assign w_at_zero = (w_q == '0);

    // Terminal count: an enabled count step that would leave the range.
    assign w_tc = en & ~load & ((x_in == DIR_UP) ? w_at_top : w_at_zero);

`ifdef JK_CNT_MOD_EN
    logic [WIDTH-1:0] w_next;

    // Next counter value from the mode, direction and terminal handling.
    always_comb begin
        w_next = w_q;
        case (w_mode)
            LOAD: begin
                w_next = load_val;
            end
            COUNT: begin
                if (x_in == DIR_UP) begin
                    if (w_at_top) begin
                        w_next = SAT ? w_max : '0;
                    end else begin
                        w_next = w_q + WIDTH'(1);
                    end
                end else begin
                    if (w_at_zero) begin
                        w_next = SAT ? w_q : w_max;
                    end else begin
                        w_next = w_q - WIDTH'(1);
                    end
                end
            end
            default: begin
                w_next = w_q;
            end
        endcase
    end

    // Set the bits that must rise, clear the bits that must fall.
    always_comb begin
        w_j = w_next & ~w_q;
        w_k = ~w_next & w_q;
    end
`else
    logic [WIDTH-1:0] w_tog;

    // Ripple toggle enables: bit i flips when every lower bit is 1 going up,
    // or every lower bit is 0 going down. Bit 0 always flips. Wrap-around
    // falls out of the ripple naturally.
    always_comb begin
        w_tog    = '0;
        w_tog[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_tog[i] = w_tog[i-1] & ((x_in == DIR_DN) ? ~w_q[i-1] : w_q[i-1]);
        end
    end

    // Per-cell J/K: load forces each bit, count toggles (unless saturating
    // at the terminal value), hold leaves every cell alone.
    always_comb begin
        w_j = '0;
        w_k = '0;
        case (w_mode)
            LOAD: begin
                w_j = load_val;
                w_k = ~load_val;
            end
            COUNT: begin
                if (!(SAT && w_tc)) begin
                    w_j = w_tog;
                    w_k = w_tog;
                end
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end
`endif

    // One JK cell per counter bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .Clk (Clk),
            .rst (rst),
            .j   (w_j[gi]),
            .k   (w_k[gi]),
            .q   (w_q[gi])
        );
    end

    // Overflow pulse: high for the cycle after a terminal event was counted.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_tc;
        end
    end

    assign q   = w_q;
    assign tc  = w_tc;
    assign ovf = r_ovf;

endmodule : jk_updown_counter
`default_nettype wire

// File: tb/tb_jk_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_updown_counter
//  Description : Self-checking bench for jk_updown_counter. Two instances
//                (wrap and saturate) share stimulus; an arithmetic model of
//                the counter is compared against both every cycle, and the
//                directed scenarios also carry hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_updown_counter;

    logic       Clk;
    logic       rst;
    logic       en;
    logic       x_in;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] mod_max;
    logic [3:0] q0, q1;
    logic       tc0, tc1, ovf0, ovf1;

    int checks   = 0;
    int failures = 0;

    // Model state for the wrap (0) and saturate (1) instances.
    int m_q0   = 0;
    int m_q1   = 0;
    int m_ovf0 = 0;
    int m_ovf1 = 0;

    jk_updown_counter #(.WIDTH(4), .SAT(1'b0)) u_dut0 (
        .Clk      (Clk),
        .rst      (rst),
        .en       (en),
        .x_in     (x_in),
        .load     (load),
        .load_val (load_val),
`ifdef JK_CNT_MOD_EN
        .mod_max  (mod_max),
`endif
        .q        (q0),
        .tc       (tc0),
        .ovf      (ovf0)
    );

    jk_updown_counter #(.WIDTH(4), .SAT(1'b1)) u_dut1 (
        .Clk      (Clk),
        .rst      (rst),
        .en       (en),
        .x_in     (x_in),
        .load     (load),
        .load_val (load_val),
`ifdef JK_CNT_MOD_EN
        .mod_max  (mod_max),
`endif
        .q        (q1),
        .tc       (tc1),
        .ovf      (ovf1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int top_val();
`ifdef JK_CNT_MOD_EN
        return int'(mod_max);
`else
        return 15;
`endif
    endfunction

    // Terminal count from the behavioural rules.
    function automatic int model_tc(input int cur);
        if (!en || load) return 0;
        if (x_in) return (cur >= top_val()) ? 1 : 0;
        return (cur == 0) ? 1 : 0;
    endfunction

    // Next counter value from the behavioural rules.
    function automatic int model_next(input int cur, input bit sat);
        int mx;
        mx = top_val();
        if (load) return int'(load_val);
        if (!en) return cur;
        if (x_in) begin
            if (cur >= mx) return sat ? mx : 0;
            return cur + 1;
        end
        if (cur == 0) return sat ? 0 : mx;
        return cur - 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model update.
    always @(posedge Clk or negedge rst) begin
        if (!rst) begin
            m_q0   <= 0;
            m_q1   <= 0;
            m_ovf0 <= 0;
            m_ovf1 <= 0;
        end else begin
            m_q0   <= model_next(m_q0, 1'b0);
            m_q1   <= model_next(m_q1, 1'b1);
            m_ovf0 <= model_tc(m_q0);
            m_ovf1 <= model_tc(m_q1);
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge Clk);
            #2;
            chk("model_q0",   32'(q0),   32'(m_q0));
            chk("model_ovf0", 32'(ovf0), 32'(m_ovf0));
            chk("model_tc0",  32'(tc0),  32'(model_tc(m_q0)));
            chk("model_q1",   32'(q1),   32'(m_q1));
            chk("model_ovf1", 32'(ovf1), 32'(m_ovf1));
            chk("model_tc1",  32'(tc1),  32'(model_tc(m_q1)));
        end
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        #3;
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        x_in     = 1'b1;
        load     = 1'b0;
        load_val = 4'h0;
        mod_max  = 4'hF;

        // Reset state.
        tick();
        tick();
        chk("rst_q0", 32'(q0), 32'd0);
        chk("rst_ovf0", 32'(ovf0), 32'd0);

        // Wrap count up through 15 -> 0.
        rst  = 1'b1;
        en   = 1'b1;
        x_in = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk("up_q0", 32'(q0), 32'(k % 16));
            chk("up_ovf0", 32'(ovf0), (k == 16) ? 32'd1 : 32'd0);
            if (k == 15) chk("up_tc0_at15", 32'(tc0), 32'd1);
        end

        // Load 2 then count down across zero.
        load     = 1'b1;
        load_val = 4'h2;
        tick();
        chk("ld2_q0", 32'(q0), 32'd2);
        load = 1'b0;
        x_in = 1'b0;
        tick(); chk("dn_q0_1",  32'(q0), 32'd1);
        tick(); chk("dn_q0_0",  32'(q0), 32'd0);
        tick(); chk("dn_q0_15", 32'(q0), 32'd15);
        chk("dn_ovf0", 32'(ovf0), 32'd1);
        tick(); chk("dn_q0_14", 32'(q0), 32'd14);
        chk("dn_ovf0_clr", 32'(ovf0), 32'd0);

        // Saturating instance held at 15.
        load     = 1'b1;
        load_val = 4'hE;
        x_in     = 1'b1;
        tick(); chk("sat_q1_14", 32'(q1), 32'd14);
        load = 1'b0;
        tick(); chk("sat_q1_15a", 32'(q1), 32'd15); chk("sat_ovf1_a", 32'(ovf1), 32'd0);
        tick(); chk("sat_q1_15b", 32'(q1), 32'd15); chk("sat_ovf1_b", 32'(ovf1), 32'd1);
        tick(); chk("sat_q1_15c", 32'(q1), 32'd15); chk("sat_ovf1_c", 32'(ovf1), 32'd1);
        x_in = 1'b0;
        tick(); chk("sat_q1_dn14", 32'(q1), 32'd14); chk("sat_ovf1_d", 32'(ovf1), 32'd0);

        // Load beats enable, then hold.
        load     = 1'b1;
        en       = 1'b1;
        load_val = 4'h9;
        tick(); chk("pri_q0", 32'(q0), 32'd9); chk("pri_ovf0", 32'(ovf0), 32'd0);
        load = 1'b0;
        en   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_q0", 32'(q0), 32'd9);
            chk("hold_tc0", 32'(tc0), 32'd0);
        end

        // Asynchronous reset between edges.
        load     = 1'b1;
        load_val = 4'h7;
        tick();
        load = 1'b0;
        @(posedge Clk);
        #1;
        chk("ar_pre_q0", 32'(q0), 32'd7);
        #1;
        rst = 1'b0;
        #1;
        chk("ar_q0", 32'(q0), 32'd0);
        chk("ar_ovf0", 32'(ovf0), 32'd0);
        @(negedge Clk);
        #3;
        rst  = 1'b1;
        en   = 1'b1;
        x_in = 1'b1;
        tick(); chk("ar_restart_q0", 32'(q0), 32'd1);

`ifdef JK_CNT_MOD_EN
        // Programmable terminal value.
        mod_max  = 4'd9;
        load     = 1'b1;
        load_val = 4'h0;
        tick();
        load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("mod_q0", 32'(q0), 32'(k % 10));
            chk("mod_ovf0", 32'(ovf0), (k == 10) ? 32'd1 : 32'd0);
        end
        load     = 1'b1;
        load_val = 4'd12;
        tick(); chk("mod_ld12", 32'(q0), 32'd12);
        load = 1'b0;
        tick(); chk("mod_wrap12", 32'(q0), 32'd0); chk("mod_ovf12", 32'(ovf0), 32'd1);
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 600; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 9) == 0);
            x_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                load_val = 4'($urandom_range(0, 15));
            end else begin
                load_val = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF;
            end
`ifdef JK_CNT_MOD_EN
            if ($urandom_range(0, 40) == 0) mod_max = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 60) == 0) begin
                @(posedge Clk);
                #($urandom_range(1, 4));
                rst = 1'b0;
                @(negedge Clk);
                #3;
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_jk_updown_counter
`default_nettype wire

// File: doc/jk_updown_counter.md
Name: jk_updown_counter

Overview:
- Parametrised synchronous up/down counter built from JK flip-flop cells. It is the successor to the 2-bit JK-based state machine driven by x_in.
- x_in selects the count direction. The block adds enable, synchronous parallel load, wrap or saturate mode, a combinational terminal-count flag and a registered overflow pulse.
- Used as a general sequencer/counter primitive in the flip-flop design library.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 2.
- SAT, 0, terminal behaviour: 0 = wrap around, 1 = saturate (hold at the limit).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  count enable.
- x_in  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  counter state; each bit is the Q of one JK cell.
- tc  output  1  terminal count, combinational: en & ~load & (x_in ? q==MAX : q==0).
- ovf  output  1  registered one-cycle pulse, high the cycle after a terminal event is counted.

Behaviour:
- Reset: rst low forces q=0 and ovf=0 immediately, independent of Clk, and holds them while low. The first update occurs on the first rising Clk edge after rst goes high.
- Priority on each edge: load > en > hold.
- Load:
  - Per bit, J=load_val[i], K=~load_val[i]; q becomes load_val next cycle.
  - ovf=0.
  - en and x_in are ignored.
- Count up (en=1, x_in=1):
  - Bit i toggles (J=K=1) when bits 0..i-1 are all 1; bit 0 always toggles.
  - Increment is modulo 2^WIDTH.
- Count down (en=1, x_in=0):
  - Bit i toggles when bits 0..i-1 are all 0.
  - Decrement is modulo 2^WIDTH.
- Hold (en=0, load=0): J=K=0 on every bit; q unchanged; ovf=0.
- MAX = 2^WIDTH-1, or mod_max when the optional feature is compiled in.
- Terminal event, i.e. tc=1 at the edge:
  - SAT=0: up at MAX goes to 0; down at 0 goes to MAX.
  - SAT=1: q holds; every cell gets J=K=0.
  - In both modes, ovf=1 for exactly the next cycle.
- Back-to-back terminal events (saturated with en held high) produce ovf high on every cycle.
- Changing x_in is legal on any cycle; it takes effect at the next edge, with no dead cycle.
- Reset asserted mid-count aborts the count; no ovf is generated.

Optional Feature:
- Macro JK_CNT_MOD_EN.
- Defined:
  - Adds input port mod_max [WIDTH], placed after load_val, and MAX = mod_max.
  - Up-count when q >= mod_max is a terminal event: wrap to 0, or with SAT=1 clamp to mod_max.
  - Down at 0 wraps to mod_max, or holds with SAT=1.
  - Cell J/K are computed from the next-state value: J=next[i]&~q[i], K=~next[i]&q[i].
- Undefined:
  - No mod_max port; MAX = 2^WIDTH-1.
  - Pure ripple-toggle J/K equations as above.

Decomposition:
- Package jk_cnt_pkg holds:
  - localparam encodings DIR_UP=1 and DIR_DN=0;
  - mode enum {HOLD, COUNT, LOAD};
  - helper function max_val(WIDTH).
- Natural sub-module jk_cell: one JK flip-flop.
  - Q_next = J&~Q | ~K&Q.
  - Asynchronous active-low rst clears Q to 0.
  - Instantiated WIDTH times via generate.
- Top-level logic computes per-bit J/K, tc and the ovf register.

Test Plan:
- WIDTH=4, SAT=0: release rst, en=1, x_in=1 for 17 cycles → q steps 0,1,…,15,0. tc high while q=15. ovf pulses once, the cycle q becomes 0.
- WIDTH=4, SAT=0: load=1, load_val=4'h2, then en=1, x_in=0 for 4 cycles → q = 2,1,0,15,14. ovf high the cycle after 0→15.
- WIDTH=4, SAT=1: load 4'hE, count up 4 cycles → q = 14,15,15,15. ovf high for each of the cycles following the held-15 edges. Then x_in=0 → q=14 and ovf=0.
- Priority and hold: load=1, en=1, load_val=4'h9 → q=9, ovf=0. Then en=0 for 3 cycles → q stays 9 and tc=0.
- Asynchronous reset: assert rst low mid-cycle at q=7 → q=0 and ovf=0 before the next Clk edge. Release → counting restarts from 0.
- JK_CNT_MOD_EN, mod_max=9, SAT=0: count up from 0 → wraps 9→0, ovf pulses. Load 12, count up → q=0 next cycle.
